// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures each high pulse in prescaled tics, removes the base-pulse
// offset and reports a clamped 8-bit position, with malformed-pulse and loss-of-signal flags.
module servo_pwm_decoder #(
  parameter int unsigned CLK_DIV       = 94,
  parameter int unsigned OFFSET        = 46,
  parameter int unsigned MIN           = 0,
  parameter int unsigned MAX           = 255,
  parameter int unsigned HOME          = 127,
  parameter int unsigned MAX_TICKS     = 400,
  parameter int unsigned TIMEOUT_TICKS = 2560
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_pwm,
  output logic [7:0] bitpos,
  output logic       valid,
  output logic       err,
  output logic       lost
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {StWaitLow, StWaitRise, StMeasure, StDone} state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync2_q, prev_q;
  logic [1:0]      settle_q, settle_d;
  logic [DivW-1:0] divcnt_q, divcnt_d;
  logic [9:0]      wcnt_q, wcnt_d, wcnt_inc;
  logic [11:0]     pcnt_q, pcnt_d;
  logic [7:0]      bitpos_q, bitpos_d, pos_clamped;
  logic            valid_q, valid_d, err_q, err_d, lost_q, lost_d;
  logic            in_sync, rise, fall, tic, too_long;
  logic signed [10:0] diff;

  assign in_sync  = sync2_q;
  assign rise     = in_sync & ~prev_q;
  assign fall     = ~in_sync & prev_q;
  assign tic      = (divcnt_q == DivW'(CLK_DIV - 1));
  assign wcnt_inc = (tic && (wcnt_q != 10'h3ff)) ? wcnt_q + 10'd1 : wcnt_q;
  assign too_long = (32'(wcnt_inc) > MAX_TICKS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StWaitLow;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      settle_q <= 2'd0;
      divcnt_q <= '0;
      wcnt_q   <= '0;
      pcnt_q   <= '0;
      bitpos_q <= 8'(HOME);
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      lost_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      sync1_q  <= in_pwm;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      settle_q <= settle_d;
      divcnt_q <= divcnt_d;
      wcnt_q   <= wcnt_d;
      pcnt_q   <= pcnt_d;
      bitpos_q <= bitpos_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      lost_q   <= lost_d;
    end
  end

  // Counters and synchroniser settling.
  always_comb begin
    // The synchroniser holds reset zeros for two cycles; ignore them so a pulse already
    // high at reset release is not mistaken for a fresh rising edge.
    settle_d = (settle_q != 2'd2) ? settle_q + 2'd1 : settle_q;

    if (rise)     divcnt_d = DivW'(CLK_DIV / 2);
    else if (tic) divcnt_d = '0;
    else          divcnt_d = divcnt_q + DivW'(1);

    if (rise)                         pcnt_d = '0;
    else if (tic && pcnt_q != 12'hfff) pcnt_d = pcnt_q + 12'd1;
    else                              pcnt_d = pcnt_q;

    if (rise)                        wcnt_d = '0;
    else if (state_q == StMeasure)   wcnt_d = wcnt_inc;
    else                             wcnt_d = wcnt_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitLow:  if (settle_q == 2'd2 && !in_sync) state_d = StWaitRise;
      StWaitRise: if (rise) state_d = StMeasure;
      StMeasure: begin
        if (too_long)  state_d = StWaitLow;
        else if (fall) state_d = StDone;
      end
      StDone:     state_d = StWaitRise;
      default:    state_d = StWaitLow;
    endcase
  end

  always_comb begin
    diff = $signed({1'b0, wcnt_q}) - $signed(11'(OFFSET));
    if (diff < $signed(11'(MIN)))      pos_clamped = 8'(MIN);
    else if (diff > $signed(11'(MAX))) pos_clamped = 8'(MAX);
    else                               pos_clamped = diff[7:0];

    valid_d  = (state_q == StDone);
    err_d    = (state_q == StMeasure) && too_long;
    bitpos_d = valid_d ? pos_clamped : bitpos_q;

    if (valid_d)                                lost_d = 1'b0;
    else if (rise)                              lost_d = lost_q;
    else if (32'(pcnt_q) >= TIMEOUT_TICKS)      lost_d = 1'b1;
    else                                        lost_d = lost_q;
  end

  assign bitpos = bitpos_q;
  assign valid  = valid_q;
  assign err    = err_q;
  assign lost   = lost_q;

endmodule
